// File: rtl/uart_program_loader_if.sv
// Programming write stream and loader status, grouped for the UART program loader.
// master: the loader drives the stream; slave: memories / top-level reset logic observe it.
interface uart_program_loader_if;
  logic        oUpgWriteEnable;
  logic [14:0] oUpgWriteAddress;
  logic [31:0] oUpgWriteData;
  logic        oUpgDone;
  logic        oBusy;
  logic        oError;

  modport master (
    output oUpgWriteEnable,
    output oUpgWriteAddress,
    output oUpgWriteData,
    output oUpgDone,
    output oBusy,
    output oError
  );

  modport slave (
    input oUpgWriteEnable,
    input oUpgWriteAddress,
    input oUpgWriteData,
    input oUpgDone,
    input oBusy,
    input oError
  );
endinterface

// File: rtl/uart_program_loader.sv
// UART boot loader: receives 8N1 bytes, assembles little-endian 32-bit words and emits one
// programming write per word, first for the instruction region (addr bit 14 = 0), then for
// the data region (addr bit 14 = 1), then raises done.
// Stream per region: 16-bit LE word count N, then N words of 4 bytes.
// Optional macro UART_LOADER_CHECKSUM_EN: each region is followed by one byte equal to the
// XOR of all its count and data bytes.
// CLKS_PER_BIT must be >= 4; MAX_WORDS must be <= 16384.
module uart_program_loader #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned MAX_WORDS    = 16384
) (
  input  logic                  iUpgClock,
  input  logic                  iUpgReset,
  input  logic                  iUartRx,
  uart_program_loader_if.master upg
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [16:0]     MaxWords = 17'(MAX_WORDS);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

`ifdef UART_LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    LdICntLo, LdICntHi, LdIWords, LdICsum,
    LdDCntLo, LdDCntHi, LdDWords, LdDCsum,
    LdDone, LdError
  } ld_state_e;
  localparam ld_state_e IEnd = LdICsum;
  localparam ld_state_e DEnd = LdDCsum;
`else
  typedef enum logic [2:0] {
    LdICntLo, LdICntHi, LdIWords,
    LdDCntLo, LdDCntHi, LdDWords,
    LdDone, LdError
  } ld_state_e;
  localparam ld_state_e IEnd = LdDCntLo;
  localparam ld_state_e DEnd = LdDone;
`endif

  // Receiver state
  logic            rx_meta_q, rx_sync_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid, frame_err, start_ok;

  // Loader state
  ld_state_e   ld_state_q, ld_state_d;
  logic [7:0]  cnt_lo_q, cnt_lo_d;
  logic [15:0] count_q, count_d;
  logic [15:0] index_q, index_d;
  logic [1:0]  byte_sel_q, byte_sel_d;
  logic [31:0] word_q, word_d;
  logic        we_q, we_d;
  logic [14:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic [15:0] rx_count;
  logic        in_data;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  // Two-flop synchronizer; line reads idle-high during reset
  always_ff @(posedge iUpgClock) begin
    if (iUpgReset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= iUartRx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Byte receiver state register
  always_ff @(posedge iUpgClock) begin
    if (iUpgReset) begin
      rx_state_q <= RxIdle;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // Byte receiver next state: mid-bit sampling, LSB first
  always_comb begin
    rx_state_d = rx_state_q;
    clk_cnt_d  = clk_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    start_ok   = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        clk_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (clk_cnt_q == HalfLast) begin
          clk_cnt_d = '0;
          if (rx_sync_q) begin
            rx_state_d = RxIdle;  // glitch, not a real start bit
          end else begin
            start_ok   = 1'b1;
            bit_cnt_d  = '0;
            rx_state_d = RxData;
          end
        end
      end
      RxData: begin
        if (clk_cnt_q == FullLast) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (clk_cnt_q == FullLast) begin
          clk_cnt_d  = '0;
          rx_state_d = RxIdle;
          if (rx_sync_q) byte_valid = 1'b1;
          else           frame_err  = 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Loader state and write-port registers
  always_ff @(posedge iUpgClock) begin
    if (iUpgReset) begin
      ld_state_q <= LdICntLo;
      cnt_lo_q   <= '0;
      count_q    <= '0;
      index_q    <= '0;
      byte_sel_q <= '0;
      word_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      ld_state_q <= ld_state_d;
      cnt_lo_q   <= cnt_lo_d;
      count_q    <= count_d;
      index_q    <= index_d;
      byte_sel_q <= byte_sel_d;
      word_q     <= word_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign rx_count = {shift_q, cnt_lo_q};
  assign in_data  = (ld_state_q == LdDCntHi) || (ld_state_q == LdDWords);

  // Loader next state: advances only on received bytes; framing errors are fatal
  always_comb begin
    ld_state_d = ld_state_q;
    cnt_lo_d   = cnt_lo_q;
    count_d    = count_q;
    index_d    = index_q;
    byte_sel_d = byte_sel_q;
    word_d     = word_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef UART_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (frame_err && ld_state_q != LdDone && ld_state_q != LdError) begin
      ld_state_d = LdError;
    end else if (byte_valid) begin
      case (ld_state_q)
        LdICntLo, LdDCntLo: begin
          cnt_lo_d   = shift_q;
          ld_state_d = (ld_state_q == LdICntLo) ? LdICntHi : LdDCntHi;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d     = shift_q;  // checksum restarts with each region
`endif
        end
        LdICntHi, LdDCntHi: begin
          count_d    = rx_count;
          index_d    = '0;
          byte_sel_d = '0;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ shift_q;
`endif
          if ({1'b0, rx_count} > MaxWords) ld_state_d = LdError;
          else if (rx_count == 16'd0)      ld_state_d = in_data ? DEnd : IEnd;
          else                             ld_state_d = in_data ? LdDWords : LdIWords;
        end
        LdIWords, LdDWords: begin
          word_d     = {shift_q, word_q[31:8]};
          byte_sel_d = byte_sel_q + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ shift_q;
`endif
          if (byte_sel_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = {in_data, index_q[13:0]};
            data_d  = {shift_q, word_q[31:8]};
            index_d = index_q + 16'd1;
            if (index_q == count_q - 16'd1) ld_state_d = in_data ? DEnd : IEnd;
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        LdICsum: ld_state_d = (shift_q == csum_q) ? LdDCntLo : LdError;
        LdDCsum: ld_state_d = (shift_q == csum_q) ? LdDone : LdError;
`endif
        default: ;  // Done / Error ignore all bytes
      endcase
    end
  end

  // Busy from first confirmed start bit until a terminal state
  always_comb begin
    busy_d = busy_q;
    if (ld_state_d == LdDone || ld_state_d == LdError) busy_d = 1'b0;
    else if (start_ok)                                  busy_d = 1'b1;
  end

  assign upg.oUpgWriteEnable  = we_q;
  assign upg.oUpgWriteAddress = addr_q;
  assign upg.oUpgWriteData    = data_q;
  assign upg.oUpgDone         = (ld_state_q == LdDone);
  assign upg.oError           = (ld_state_q == LdError);
  assign upg.oBusy            = busy_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: expected writes are queued as bytes are sent and
// checked when the write strobe appears. Streams include checksum bytes when
// UART_LOADER_CHECKSUM_EN is defined.
module tb_uart_program_loader;
  localparam int unsigned Cpb = 4;

  logic iUpgClock = 1'b0;
  logic iUpgReset = 1'b1;
  logic iUartRx   = 1'b1;
  int   n_checks  = 0;
  int   n_errs    = 0;
  logic [46:0] exp_q[$];

  uart_program_loader_if bus ();

  uart_program_loader #(
    .CLKS_PER_BIT(Cpb),
    .MAX_WORDS   (16384)
  ) dut (
    .iUpgClock(iUpgClock),
    .iUpgReset(iUpgReset),
    .iUartRx  (iUartRx),
    .upg      (bus.master)
  );

  always #5 iUpgClock = ~iUpgClock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge iUpgClock);
    iUpgReset = 1'b1;
    iUartRx   = 1'b1;
    repeat (3) @(negedge iUpgClock);
    iUpgReset = 1'b0;
    repeat (2) @(negedge iUpgClock);
  endtask

  task automatic drive_bit(input logic v);
    iUartRx = v;
    repeat (Cpb) @(negedge iUpgClock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  // Full region: count, up to two words, checksum when built in; queues the expected writes.
  task automatic send_region(input logic region, input int n, input logic [31:0] w0,
                             input logic [31:0] w1);
    logic [15:0] cnt;
    logic [7:0]  cs;
    logic [31:0] w;
    cnt = 16'(n);
    cs  = cnt[7:0] ^ cnt[15:8];
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      exp_q.push_back({region, 14'(i), w});
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      send_word(w);
    end
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(cs);
`endif
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic busy);
    repeat (4) @(negedge iUpgClock);
    check({tag, "_done"},  64'(bus.oUpgDone), 64'(done));
    check({tag, "_error"}, 64'(bus.oError),   64'(err));
    check({tag, "_busy"},  64'(bus.oBusy),    64'(busy));
    check({tag, "_left"},  64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    fork
      begin : monitor
        logic [46:0] e;
        forever begin
          @(negedge iUpgClock);
          if (bus.oUpgWriteEnable) begin
            check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("wr_addr", 64'(bus.oUpgWriteAddress), 64'(e[46:32]));
              check("wr_data", 64'(bus.oUpgWriteData),    64'(e[31:0]));
            end
          end
        end
      end
    join_none

    // Reset state
    do_reset();
    check("rst_we",    64'(bus.oUpgWriteEnable),  64'd0);
    check("rst_addr",  64'(bus.oUpgWriteAddress), 64'd0);
    check("rst_data",  64'(bus.oUpgWriteData),    64'd0);
    check("rst_done",  64'(bus.oUpgDone),         64'd0);
    check("rst_busy",  64'(bus.oBusy),            64'd0);
    check("rst_error", 64'(bus.oError),           64'd0);

    // A one-cycle low pulse is a glitch: no start confirmation, busy stays low
    iUartRx = 1'b0;
    @(negedge iUpgClock);
    iUartRx = 1'b1;
    repeat (20) @(negedge iUpgClock);
    check("glitch_busy", 64'(bus.oBusy), 64'd0);

    // Test 1: two instruction words, empty data region
    send_byte(8'h02);
    check("t1_busy_rise", 64'(bus.oBusy), 64'd1);
    send_byte(8'h00);
    exp_q.push_back({1'b0, 14'd0, 32'h1234_5678});
    exp_q.push_back({1'b0, 14'd1, 32'hDEAD_BEEF});
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(8'h02 ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
`endif
    send_region(1'b1, 0, 32'h0, 32'h0);
    check_status("t1", 1'b1, 1'b0, 1'b0);
    // Bytes after done are ignored
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h5555_AAAA);
    check_status("t1_post", 1'b1, 1'b0, 1'b0);

    // Test 2: empty instruction region, one data word
    do_reset();
    send_region(1'b0, 0, 32'h0, 32'h0);
    send_region(1'b1, 1, 32'hCAFE_F00D, 32'h0);
    check_status("t2", 1'b1, 1'b0, 1'b0);
    check("t2_hold_addr", 64'(bus.oUpgWriteAddress), 64'h4000);
    check("t2_hold_data", 64'(bus.oUpgWriteData),    64'hCAFE_F00D);

    // Test 3: framing error on the 3rd byte; later bytes ignored
    do_reset();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h78, 1'b0);
    repeat (3 * Cpb) @(negedge iUpgClock);
    check_status("t3", 1'b0, 1'b1, 1'b0);
    send_word(32'h1234_5678);
    send_byte(8'h00);
    send_byte(8'h00);
    check_status("t3_post", 1'b0, 1'b1, 1'b0);

    // Test 4: count above the region limit
    do_reset();
    send_byte(8'h01);
    send_byte(8'h40);
    send_word(32'h0102_0304);
    check_status("t4", 1'b0, 1'b1, 1'b0);

    // Test 5: reset mid-word, then a fresh stream; no stale bytes in the first write
    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    check("t5_busy_clr", 64'(bus.oBusy), 64'd0);
    send_region(1'b0, 1, 32'h0BAD_C0DE, 32'h0);
    send_region(1'b1, 0, 32'h0, 32'h0);
    check_status("t5", 1'b1, 1'b0, 1'b0);

`ifdef UART_LOADER_CHECKSUM_EN
    // Test 6: explicit checksum bytes, good then bad
    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    exp_q.push_back({1'b0, 14'd0, 32'h0000_0011});
    send_word(32'h0000_0011);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check_status("t6_good", 1'b1, 1'b0, 1'b0);

    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    exp_q.push_back({1'b0, 14'd0, 32'h0000_0011});
    send_word(32'h0000_0011);
    send_byte(8'h11);
    check_status("t6_bad", 1'b0, 1'b1, 1'b0);
`endif

    repeat (10) @(negedge iUpgClock);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
UART boot loader sitting directly upstream of the instruction and data memories. It replaces the vendor UART programmer IP and produces the same style of programming write stream.
- It receives a framed 8N1 byte stream from the PC and assembles little-endian 32-bit words.
- It emits one write per word, with address bit 14 selecting the region (0 = instruction memory, 1 = data memory), then raises done.
- The top level holds the CPU in reset until done is asserted.

Parameters:
- CLKS_PER_BIT, 87: iUpgClock cycles per UART bit; minimum legal value is 4.
- MAX_WORDS, 16384: maximum word count per region; must be ≤ 16384 (14-bit word address).

Ports:
- iUpgClock  in  1  single clock for all logic.
- iUpgReset  in  1  synchronous, active-high reset.
- iUartRx  in  1  UART line from the PC; idles high; asynchronous to iUpgClock.
- oUpgWriteEnable  out  1  one-cycle write strobe.
- oUpgWriteAddress  out  15  bit 14 = region; bits 13:0 = word index.
- oUpgWriteData  out  32  assembled word; valid while oUpgWriteEnable is high.
- oUpgDone  out  1  both regions loaded; sticky until reset.
- oBusy  out  1  high from the first start bit until done or error.
- oError  out  1  fatal protocol or framing error; sticky until reset.

Behaviour:
- Reset:
  - All outputs are 0.
  - Both FSMs go to their idle states; the byte and word counters clear.
  - Reset asserted mid-frame or mid-load aborts silently. No write is issued in the reset cycle or the following cycle.
- Input sync: iUartRx passes through a 2-flop synchronizer. It is treated as high during reset.
- Byte receiver FSM:
  - RX_IDLE: wait for the synced line to go low → RX_START.
  - RX_START: wait CLKS_PER_BIT/2 cycles, then resample.
    - Line high → glitch; return to RX_IDLE without error.
    - Line low → RX_DATA.
  - RX_DATA: sample 8 bits LSB-first, one every CLKS_PER_BIT cycles at mid-bit → RX_STOP.
  - RX_STOP: sample at mid-bit.
    - 1 → pulse an internal byte_valid for one cycle.
    - 0 → framing error: oError = 1; the loader FSM goes to ERROR.
  - In all stop-bit cases, return to RX_IDLE.
- Loader FSM states: I_CNT_LO, I_CNT_HI, I_WORDS, D_CNT_LO, D_CNT_HI, D_WORDS, DONE, ERROR. It advances only on byte_valid.
  - *_CNT_LO / *_CNT_HI: capture a 16-bit little-endian word count N.
    - N > MAX_WORDS → ERROR.
    - N == 0 → skip directly to the next region's CNT_LO, or to DONE after the data region.
  - *_WORDS: bytes fill word[7:0], [15:8], [23:16], [31:24] in arrival order.
    - The cycle after the 4th byte_valid: oUpgWriteEnable = 1 for exactly one cycle.
    - oUpgWriteAddress = {region, index}, with index starting at 0 per region; oUpgWriteData = the assembled word.
    - Then index++. After the write with index == N-1, move to the next region or DONE.
  - DONE: oUpgDone = 1, oBusy = 0. Further bytes are ignored and no writes occur.
  - ERROR: oError = 1, oBusy = 0, oUpgDone stays 0. All bytes are ignored until reset.
- oBusy rises in the cycle after the first valid start-bit confirmation after reset.
- Throughput: at most one write per 4 bytes. Byte spacing (≥ 10·CLKS_PER_BIT cycles) guarantees the write completes before the next byte_valid, so no buffering beyond the word shift register is needed.
- oUpgWriteAddress and oUpgWriteData hold their last values when write enable is low.

Optional Feature:
UART_LOADER_CHECKSUM_EN
- Defined:
  - After the last word of each region, including a region with N == 0, one extra byte is expected.
  - It must equal the XOR of all count and data bytes of that region.
  - Match → proceed to the next region or DONE. Mismatch → ERROR.
  - The extra states I_CSUM and D_CSUM are added to the loader FSM.
- Undefined: no checksum byte is expected and the CSUM states do not exist.
- Bench streams must match the build.

Test Plan:
1. CLKS_PER_BIT = 4; send 02 00, words 0x12345678 and 0xDEADBEEF, then 00 00 → writes (addr 0x0000, 0x12345678) and (0x0001, 0xDEADBEEF); oUpgDone rises; oError = 0.
2. Send 00 00, then 01 00, then 0xCAFEF00D → a single write (addr 0x4000, 0xCAFEF00D); then done.
3. Stop bit = 0 on the 3rd byte → oError = 1 after that frame; no writes; later bytes ignored; oUpgDone stays 0.
4. Count 0x4001 in the instruction region → ERROR; no writes.
5. Reset pulse after 2 of 4 data bytes, then a fresh valid stream → the first write is at addr 0x0000 with the new word; no stale bytes appear in it.
6. With UART_LOADER_CHECKSUM_EN: 01 00, 0x00000011, checksum 0x10, then 00 00 00 → done. The same stream with checksum 0x11 → ERROR after the write at addr 0x0000.
